// File: rtl/systolic_sequencer.sv
// Command sequencer for the ARR_SIZE x ARR_SIZE systolic array: weight preload and matmul phases.
// Optional SEQ_PERF_CNT_EN adds saturating busy/stall cycle counters (perf_cycles, perf_stall).
module systolic_sequencer #(
    parameter int ARR_SIZE  = 4,
    parameter int ADDR_W    = 15,
    parameter int LEN_W     = 8,
    parameter int OP_ADDR_W = 4,
    localparam int SEL_W    = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_W-1:0]    cmd_base,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 inp_empty,
    output logic                 wt_rd_en,
    output logic [ADDR_W-1:0]    wt_addr,
    output logic                 inp_rd_en,
    output logic [ADDR_W-1:0]    inp_addr,
    output logic                 mac_wt_load,
    output logic                 mac_en,
    output logic                 acc_reset,
    output logic [SEL_W-1:0]     acc_sel,
    output logic                 op_wr_en,
    output logic [OP_ADDR_W-1:0] op_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stall
`endif
);

    localparam int FLUSH_N = 2 * ARR_SIZE - 1;
    localparam int CNT_W   = (LEN_W > $clog2(2 * ARR_SIZE)) ? LEN_W : $clog2(2 * ARR_SIZE);
    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(ARR_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(FLUSH_N - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CLR, STREAM, FLUSH, DRAIN, FIN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  base_q;
    logic [LEN_W-1:0]   len_q;
    logic               flush_step;
    logic               wt_load_p1, mac_step_p1, done_nop_p1, err_p1;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cmd_ready  = 1'b0;
        wt_rd_en   = 1'b0;
        wt_addr    = '0;
        inp_rd_en  = 1'b0;
        inp_addr   = '0;
        acc_reset  = 1'b0;
        acc_sel    = '0;
        op_wr_en   = 1'b0;
        op_addr    = '0;
        flush_step = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                cnt_nxt   = '0;
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b01:   state_nxt = LOAD;
                        2'b10:   state_nxt = CLR;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            LOAD: begin
                wt_rd_en = 1'b1;
                wt_addr  = base_q + ADDR_W'(cnt);
                if (cnt == LAST_ROW) begin
                    state_nxt = FIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CLR: begin
                acc_reset = 1'b1;
                cnt_nxt   = '0;
                state_nxt = (len_q == '0) ? FLUSH : STREAM;
            end
            STREAM: begin
                // the address holds on the current element while the buffer is empty
                inp_addr = base_q + ADDR_W'(cnt);
                if (!inp_empty) begin
                    inp_rd_en = 1'b1;
                    if (cnt == CNT_W'(len_q) - CNT_W'(1)) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_step = 1'b1;
                if (cnt == LAST_FLUSH) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRAIN: begin
                op_wr_en = 1'b1;
                op_addr  = OP_ADDR_W'(cnt);
                acc_sel  = SEL_W'(cnt);
                if (cnt == LAST_ROW) begin
                    state_nxt = FIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy    = (state != IDLE);
        done    = (state == FIN) || done_nop_p1;
        cmd_err = err_p1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wt_load_p1  <= 1'b0;
            mac_step_p1 <= 1'b0;
            done_nop_p1 <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            // stage p1: array sidebands line up with the buffer's one-cycle read latency
            wt_load_p1  <= wt_rd_en;
            mac_step_p1 <= inp_rd_en || flush_step;
            done_nop_p1 <= cmd_valid && cmd_ready && (cmd_op == 2'b00);
            err_p1      <= cmd_valid && cmd_ready && (cmd_op == 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            base_q <= cmd_base;
            len_q  <= cmd_len;
        end
    end

    assign mac_wt_load = wt_load_p1;
    assign mac_en      = mac_step_p1;

`ifdef SEQ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy)
                perf_cycles <= sat_inc(perf_cycles);
            if (state == STREAM && inp_empty)
                perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer (ARR_SIZE=4); build with SEQ_PERF_CNT_EN to cover the perf counters.
module tb_systolic_sequencer;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int LW = 8;
    localparam int OW = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_base = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          inp_empty = 1'b0;
    logic          wt_rd_en, inp_rd_en, mac_wt_load, mac_en, acc_reset;
    logic [AW-1:0] wt_addr, inp_addr;
    logic [SW-1:0] acc_sel;
    logic          op_wr_en, busy, done, cmd_err;
    logic [OW-1:0] op_addr;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]   perf_cycles, perf_stall;
`endif

    systolic_sequencer #(.ARR_SIZE(N), .ADDR_W(AW), .LEN_W(LW), .OP_ADDR_W(OW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len), .inp_empty(inp_empty),
        .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .inp_rd_en(inp_rd_en), .inp_addr(inp_addr),
        .mac_wt_load(mac_wt_load), .mac_en(mac_en), .acc_reset(acc_reset), .acc_sel(acc_sel),
        .op_wr_en(op_wr_en), .op_addr(op_addr), .busy(busy), .done(done), .cmd_err(cmd_err)
`ifdef SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_done = 0, n_err = 0, n_mac = 0, n_wl = 0, n_op = 0;
    int done_cyc = 0, err_cyc = 0;
    logic [31:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] k, input int v);
        return {k, 28'(v)};
    endfunction

    task automatic sb_cmp(input string tag, input logic [31:0] got);
        if (sb.size() == 0) chk({tag, "_unexpected"}, got, 32'd0);
        else                chk(tag, got, sb.pop_front());
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (acc_reset) sb_cmp("acc_reset", ev(4'd3, 0));
            if (wt_rd_en)  sb_cmp("wt_addr", ev(4'd1, int'(wt_addr)));
            if (inp_rd_en) sb_cmp("inp_addr", ev(4'd2, int'(inp_addr)));
            if (op_wr_en) begin
                sb_cmp("op_wr", ev(4'd4, int'(acc_sel) * 256 + int'(op_addr)));
                n_op++;
            end
            if (done) begin
                sb_cmp("done", ev(4'd5, 0));
                n_done++;
                done_cyc = cyc;
            end
            if (cmd_err) begin
                sb_cmp("cmd_err", ev(4'd6, 0));
                n_err++;
                err_cyc = cyc;
            end
            if (mac_en)      n_mac++;
            if (mac_wt_load) n_wl++;
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] base,
                           input logic [LW-1:0] len, input int stall);
        int acc, d0, e0, m0, w0, t, lat_exp, ev_cyc;
        logic [AW-1:0] a;
`ifdef SEQ_PERF_CNT_EN
        logic [31:0] pc0, ps0;
`endif
        lat_exp = 2;
        if (op == 2'b01) begin
            for (int i = 0; i < N; i++) begin
                a = base + AW'(i);
                sb.push_back(ev(4'd1, int'(a)));
            end
            sb.push_back(ev(4'd5, 0));
            lat_exp = N + 2;
        end else if (op == 2'b10) begin
            sb.push_back(ev(4'd3, 0));
            for (int k = 0; k < int'(len); k++) begin
                a = base + AW'(k);
                sb.push_back(ev(4'd2, int'(a)));
            end
            for (int j = 0; j < N; j++) sb.push_back(ev(4'd4, j * 256 + j));
            sb.push_back(ev(4'd5, 0));
            lat_exp = int'(len) + stall + 3 * N + 2;
        end else if (op == 2'b00) begin
            sb.push_back(ev(4'd5, 0));
        end else begin
            sb.push_back(ev(4'd6, 0));
        end

        @(negedge clk); #1;
        t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); #1; t++; end
        d0 = n_done; e0 = n_err; m0 = n_mac; w0 = n_wl;
`ifdef SEQ_PERF_CNT_EN
        pc0 = perf_cycles; ps0 = perf_stall;
`endif
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;

        if (stall > 0) begin
            t = 0;
            while (!inp_rd_en && t < 100) begin @(negedge clk); #1; t++; end
            @(posedge clk); #1;
            inp_empty = 1'b1;
            @(negedge clk); #1;
            chk("stall_addr", 32'(inp_addr), 32'(base + AW'(1)));
            chk("stall_rd", 32'(inp_rd_en), 32'd0);
            repeat (stall) @(posedge clk);
            #1 inp_empty = 1'b0;
        end

        t = 0;
        while (n_done == d0 && n_err == e0 && t < 200) begin @(negedge clk); #1; t++; end
        chk("completion", n_done + n_err - d0 - e0, 1);
        ev_cyc = (op == 2'b11) ? err_cyc : done_cyc;
        chk("latency", ev_cyc - acc + 2, lat_exp);

        if (op == 2'b01 || op == 2'b10) begin
            chk("ready_in_fin", 32'(cmd_ready), 32'd0);
            @(negedge clk); #1;
            chk("ready_after_done", 32'(cmd_ready), 32'd1);
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("mac_wt_load_cnt", n_wl - w0, (op == 2'b01) ? N : 0);
            chk("mac_en_cnt", n_mac - m0, (op == 2'b10) ? int'(len) + 2 * N - 1 : 0);
`ifdef SEQ_PERF_CNT_EN
            chk("perf_cycles", perf_cycles - pc0, ev_cyc - acc + 1);
            chk("perf_stall", perf_stall - ps0, stall);
`endif
        end
        if (op == 2'b11) begin
            repeat (3) @(negedge clk);
            #1 chk("err_no_done", n_done - d0, 0);
        end
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic reset_mid();
        int t, d0, o0;
        sb.push_back(ev(4'd3, 0));
        sb.push_back(ev(4'd2, 32'h20));
        for (int j = 0; j < N; j++) sb.push_back(ev(4'd4, j * 256 + j));
        sb.push_back(ev(4'd5, 0));
        @(negedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_base = AW'(32'h20); cmd_len = LW'(1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        t = 0;
        while (!(op_wr_en && op_addr == OW'(1)) && t < 100) begin @(negedge clk); #1; t++; end
        chk("reach_drain_j1", 32'({op_wr_en, op_addr}), 32'h11);
        reset = 1'b0;
        #1;
        chk("rst_ctl", 32'({cmd_ready, wt_rd_en, inp_rd_en, mac_wt_load, mac_en, acc_reset,
                             op_wr_en, busy, done, cmd_err, acc_sel, op_addr}), 32'h8000);
        chk("rst_addr", 32'({wt_addr, inp_addr}), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        chk("rst_perf", perf_cycles | perf_stall, 32'd0);
`endif
        sb.delete();
        d0 = n_done; o0 = n_op;
        @(posedge clk); @(posedge clk); #2 reset = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        chk("post_rst_no_done", n_done - d0, 0);
        chk("post_rst_no_wr", n_op - o0, 0);
    endtask

    initial begin
        #12;
        chk("reset_ctl", 32'({cmd_ready, wt_rd_en, inp_rd_en, mac_wt_load, mac_en, acc_reset,
                               op_wr_en, busy, done, cmd_err, acc_sel, op_addr}), 32'h8000);
        chk("reset_addr", 32'({wt_addr, inp_addr}), 32'd0);
        @(negedge clk) reset = 1'b1;

        run_cmd(2'b01, AW'(32'h0010), '0, 0);
        run_cmd(2'b10, AW'(32'h0100), LW'(3), 0);
        run_cmd(2'b10, AW'(32'h0100), LW'(3), 2);
        inp_empty = 1'b1;
        run_cmd(2'b01, AW'(32'h7FFE), '0, 0);
        inp_empty = 1'b0;
        run_cmd(2'b10, AW'(32'h0200), LW'(0), 0);
        run_cmd(2'b00, '0, '0, 0);
        run_cmd(2'b11, '0, '0, 0);
        for (int r = 0; r < 3; r++)
            run_cmd(2'b10, AW'($urandom), LW'($urandom_range(1, 6)), 0);
        reset_mid();
        run_cmd(2'b01, AW'(32'h0040), '0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
